frequency_band_timer: RTL and testbench

FREQUENCY_BAND_TIMER -- requirements
Module: frequency_band_timer

---
 rtl/frequency_band_timer.sv | 142 ++++++++++++++
 tb/tb_frequency_band_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_band_timer.sv
// Classifies tone periods on sample_data into two frequency bands and accumulates time per band.
// Optional input synchronizer: define FREQUENCY_BAND_TIMER_SYNC_EN (adds 2 clocks of latency).
module frequency_band_timer #(
   parameter int unsigned FREQUENCY_1         = 9000,
   parameter int unsigned FREQUENCY_2         = 11000,
   parameter int unsigned FREQUENCY_DEVIATION = 10,
   parameter int unsigned CLOCK               = 100000000
) (
   input  logic        clock,
   input  logic        s00_axi_aresetn,
   input  logic        sample_data,
   input  logic        enable,
   input  logic        clear,
   output logic [31:0] f1_value,
   output logic [31:0] f2_value,
   output logic [15:0] miss_count,
   output logic        period_valid,
   output logic [1:0]  band
);

   localparam int unsigned CNT_W  = 32;
   localparam int unsigned MISS_W = 16;

   localparam int unsigned P1    = CLOCK / FREQUENCY_1;
   localparam int unsigned P2    = CLOCK / FREQUENCY_2;
   localparam int unsigned B1_LO = P1 * (100 - FREQUENCY_DEVIATION) / 100;
   localparam int unsigned B1_HI = P1 * (100 + FREQUENCY_DEVIATION) / 100;
   localparam int unsigned B2_LO = P2 * (100 - FREQUENCY_DEVIATION) / 100;
   localparam int unsigned B2_HI = P2 * (100 + FREQUENCY_DEVIATION) / 100;

   localparam logic [1:0] BAND_NONE = 2'd0;
   localparam logic [1:0] BAND_1    = 2'd1;
   localparam logic [1:0] BAND_2    = 2'd2;

   typedef enum logic {ARM, MEASURE} state_t;

   state_t             state;
   logic               s_in;
   logic               s_q;
   logic               s_qd;
   logic               rise;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   period_q;
   logic               done_q;
   logic               in_b1;
   logic               in_b2;
   logic [CNT_W:0]     sum1;
   logic [CNT_W:0]     sum2;

`ifdef FREQUENCY_BAND_TIMER_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchronizer for an asynchronous tone input
   always_ff @(posedge clock or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], sample_data};
      end
   end

   assign s_in = sync_q[1];
`else
   assign s_in = sample_data;
`endif

   assign rise  = s_q & ~s_qd;
   assign in_b1 = (period_q >= B1_LO) && (period_q <= B1_HI);
   assign in_b2 = (period_q >= B2_LO) && (period_q <= B2_HI);
   assign sum1  = {1'b0, f1_value} + {1'b0, period_q};
   assign sum2  = {1'b0, f2_value} + {1'b0, period_q};

   // Edge detect, period measurement FSM and saturating accumulators
   always_ff @(posedge clock or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         s_q          <= 1'b0;
         s_qd         <= 1'b0;
         state        <= ARM;
         count        <= '0;
         period_q     <= '0;
         done_q       <= 1'b0;
         f1_value     <= '0;
         f2_value     <= '0;
         miss_count   <= '0;
         period_valid <= 1'b0;
         band         <= BAND_NONE;
      end else begin
         s_q          <= s_in;
         s_qd         <= s_q;
         done_q       <= 1'b0;
         period_valid <= 1'b0;
         if (!clear) begin
            state      <= ARM;
            count      <= '0;
            f1_value   <= '0;
            f2_value   <= '0;
            miss_count <= '0;
            band       <= BAND_NONE;
         end else begin
            if (!enable) begin
               state <= ARM;
            end else begin
               case (state)
                  ARM: begin
                     if (rise) begin
                        count <= CNT_W'(1);
                        state <= MEASURE;
                     end
                  end
                  MEASURE: begin
                     if (rise) begin
                        period_q <= count;
                        done_q   <= 1'b1;
                        count    <= CNT_W'(1);
                     end else if (count != '1) begin
                        count <= count + CNT_W'(1);
                     end
                  end
                  default: state <= ARM;
               endcase
            end
            // Classification one clock after the period is captured; band 1 wins overlaps
            if (done_q) begin
               period_valid <= 1'b1;
               if (in_b1) begin
                  f1_value <= sum1[CNT_W] ? '1 : sum1[CNT_W-1:0];
                  band     <= BAND_1;
               end else if (in_b2) begin
                  f2_value <= sum2[CNT_W] ? '1 : sum2[CNT_W-1:0];
                  band     <= BAND_2;
               end else begin
                  if (miss_count != '1) begin
                     miss_count <= miss_count + MISS_W'(1);
                  end
                  band <= BAND_NONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_frequency_band_timer.sv
// Bench for frequency_band_timer: vector table of periods plus hand-written reset/clear/enable/saturation sequences.
module tb_frequency_band_timer;

   logic        clock;
   logic        rst_n;
   logic        sample_data;
   logic        enable;
   logic        clear;
   logic [31:0] f1_value;
   logic [31:0] f2_value;
   logic [15:0] miss_count;
   logic        period_valid;
   logic [1:0]  band;

   frequency_band_timer #(
      .FREQUENCY_1(100),
      .FREQUENCY_2(50),
      .FREQUENCY_DEVIATION(10),
      .CLOCK(1000)
   ) dut (
      .clock(clock),
      .s00_axi_aresetn(rst_n),
      .sample_data(sample_data),
      .enable(enable),
      .clear(clear),
      .f1_value(f1_value),
      .f2_value(f2_value),
      .miss_count(miss_count),
      .period_valid(period_valid),
      .band(band)
   );

   typedef struct {
      int unsigned period;
      logic [1:0]  band;
   } vec_t;

   typedef struct {
      logic [1:0]  band;
      logic [31:0] f1;
      logic [31:0] f2;
      logic [15:0] miss;
   } exp_t;

   localparam int unsigned NVEC = 13;
   localparam logic [1:0]  NO_PUSH = 2'd3;

   vec_t        vecs[NVEC];
   exp_t        sb[$];
   int unsigned n_cmp;
   int unsigned n_err;
   int unsigned n_pulse;
   logic [31:0] m_f1;
   logic [31:0] m_f2;
   logic [15:0] m_miss;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: update expected accumulators for one finished period
   task automatic push_exp(input logic [1:0] b, input int unsigned p);
      exp_t e;
      logic [32:0] s;
      if (b == 2'd1) begin
         s = {1'b0, m_f1} + 33'(p);
         m_f1 = s[32] ? 32'hFFFF_FFFF : s[31:0];
      end else if (b == 2'd2) begin
         s = {1'b0, m_f2} + 33'(p);
         m_f2 = s[32] ? 32'hFFFF_FFFF : s[31:0];
      end else if (m_miss != 16'hFFFF) begin
         m_miss = m_miss + 16'd1;
      end
      e.band = b;
      e.f1   = m_f1;
      e.f2   = m_f2;
      e.miss = m_miss;
      sb.push_back(e);
   endtask

   // Sample is high at entry (period start); produce the rise that ends a period of p cycles
   task automatic period(input int unsigned p, input logic [1:0] b);
      int unsigned h;
      h = p / 2;
      repeat (h) @(negedge clock);
      sample_data = 1'b0;
      repeat (p - h) @(negedge clock);
      sample_data = 1'b1;
      if (b != NO_PUSH) push_exp(b, p);
   endtask

   task automatic arm();
      sample_data = 1'b0;
      repeat (2) @(negedge clock);
      sample_data = 1'b1;
   endtask

   task automatic finish_seq(input string name);
      repeat (6) @(negedge clock);
      sample_data = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clock);
      enable = 1'b1;
      check(name, 32'(sb.size()), 32'd0);
   endtask

   // Scoreboard consumer: compare every classification pulse against the queued expectation
   always @(negedge clock) begin
      if (period_valid) begin
         n_pulse++;
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("band", 32'(band), 32'(e.band));
            check("f1_value", f1_value, e.f1);
            check("f2_value", f2_value, e.f2);
            check("miss_count", 32'(miss_count), 32'(e.miss));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;
      n_cmp = 0; n_err = 0; n_pulse = 0;
      m_f1 = '0; m_f2 = '0; m_miss = '0;

      vecs[0]  = '{10, 2'd1}; vecs[1]  = '{10, 2'd1}; vecs[2]  = '{10, 2'd1};
      vecs[3]  = '{10, 2'd1}; vecs[4]  = '{20, 2'd2}; vecs[5]  = '{20, 2'd2};
      vecs[6]  = '{14, 2'd0}; vecs[7]  = '{14, 2'd0}; vecs[8]  = '{9,  2'd1};
      vecs[9]  = '{11, 2'd1}; vecs[10] = '{8,  2'd0}; vecs[11] = '{12, 2'd0};
      vecs[12] = '{18, 2'd2};

      rst_n = 1'b0; enable = 1'b0; clear = 1'b1; sample_data = 1'b0;
      #12;
      check("rst_f1", f1_value, 32'd0);
      check("rst_f2", f2_value, 32'd0);
      check("rst_miss", 32'(miss_count), 32'd0);
      check("rst_band", 32'(band), 32'd0);
      check("rst_pv", 32'(period_valid), 32'd0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      enable = 1'b1;
      @(negedge clock);

      // Vector table: first rise arms, each entry is one classified period
      sample_data = 1'b1;
      for (int i = 0; i < int'(NVEC); i++) period(vecs[i].period, vecs[i].band);
      finish_seq("table_drain");
      check("table_pulses", n_pulse, NVEC);

      // Upper window boundaries and far misses
      arm();
      period(22, 2'd2);
      period(17, 2'd0);
      period(23, 2'd0);
      period(2, 2'd0);
      finish_seq("edge_drain");

      // Saturation of f1_value and miss_count
      force dut.f1_value = 32'hFFFF_FFF8;
      force dut.miss_count = 16'hFFFE;
      @(negedge clock);
      release dut.f1_value;
      release dut.miss_count;
      m_f1 = 32'hFFFF_FFF8;
      m_miss = 16'hFFFE;
      arm();
      period(10, 2'd1);
      period(10, 2'd1);
      period(30, 2'd0);
      period(30, 2'd0);
      finish_seq("sat_drain");

      // Clear together with a band-1 rise: nothing classified, next rise only arms
      arm();
      period(10, NO_PUSH);
      clear = 1'b0;
      repeat (4) @(negedge clock);
      check("clr_f1", f1_value, 32'd0);
      check("clr_f2", f2_value, 32'd0);
      check("clr_miss", 32'(miss_count), 32'd0);
      check("clr_band", 32'(band), 32'd0);
      clear = 1'b1;
      m_f1 = '0; m_f2 = '0; m_miss = '0;
      arm();
      period(10, 2'd1);
      finish_seq("clr_drain");

      // Asynchronous reset mid-period, then latency of the first real classification
      arm();
      repeat (5) @(negedge clock);
      sample_data = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_f1", f1_value, 32'd0);
      check("mid_rst_band", 32'(band), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;
      m_f1 = '0; m_f2 = '0; m_miss = '0;
      arm();
      repeat (5) @(negedge clock);
      sample_data = 1'b0;
      repeat (5) @(negedge clock);
      sample_data = 1'b1;
      push_exp(2'd1, 10);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         if (period_valid && lat == 0) lat = 32'(i);
      end
      check("latency", lat, 32'd3);
      finish_seq("rst_drain");

      // Enable drop mid-period discards the partial period and holds results
      arm();
      period(4, NO_PUSH);
      sample_data = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clock);
      check("hold_f1", f1_value, m_f1);
      check("hold_band", 32'(band), 32'd1);
      enable = 1'b1;
      arm();
      period(10, 2'd1);
      finish_seq("en_drain");
      check("final_f1", f1_value, 32'd20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
